sp_if_ddr_acc_resp: RTL

Responder side of the signal-processing DDR access command interface (start/wxr/area/addr/size in, endp out).
- Takes one access command from the SP-IF controller and executes it as Avalon-MM burst reads or writes to the DDR controller.
- Streams read beats to the Rx input buffer and pulls write beats from the Tx output RAM.
- Returns a single completion pulse.

---
 rtl/sp_if_ddr_acc_resp.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sp_if_ddr_acc_resp.sv
`default_nettype none
// ============================================================================
// sp_if_ddr_acc_resp : SP-IF DDR access responder, Avalon-MM burst engine.
// Rev 1.0 | optional stall watchdog enabled by defining SP_IF_DDR_TMO_EN
// ============================================================================
module sp_if_ddr_acc_resp #(
   parameter int unsigned P_BURST_MAX  = 16,
   parameter logic [26:0] P_AREA_WORDS = 27'h0100000,
   parameter logic [15:0] P_TMO_CYC    = 16'hFFFF
) (
   input  logic         i_clk156m,
   input  logic         i_arst,
   input  logic         i_ddr_start,
   input  logic         i_ddr_wxr,
   input  logic [3:0]   i_ddr_area,
   input  logic [26:0]  i_ddr_addr,
   input  logic [31:0]  i_ddr_size,
   output logic         o_ddr_endp,
   output logic         o_busy,
   output logic [26:0]  o_avm_address,
   output logic         o_avm_read,
   output logic         o_avm_write,
   output logic [4:0]   o_avm_burstcount,
   output logic [127:0] o_avm_writedata,
   input  logic         i_avm_waitrequest,
   input  logic [127:0] i_avm_readdata,
   input  logic         i_avm_readdatavalid,
   input  logic [127:0] i_txd_data,
   input  logic         i_txd_valid,
   output logic         o_txd_ready,
   output logic [127:0] o_rxd_data,
   output logic         o_rxd_valid,
   output logic         o_rxd_last,
   output logic         o_tmo_err
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD     = 3'd1;
   localparam logic [2:0] S_RD_REQ   = 3'd2;
   localparam logic [2:0] S_RD_WAIT  = 3'd3;
   localparam logic [2:0] S_WR_BURST = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [4:0] c_BURST_MAX = 5'(P_BURST_MAX);

   logic [2:0]   r_state;
   logic [2:0]   w_state_nxt;
   logic         r_start_d;
   logic         r_wxr;
   logic [26:0]  r_addr;
   logic [27:0]  r_rem;
   logic [4:0]   r_blen;
   logic [4:0]   r_beat;
   logic [127:0] r_rxd_data;
   logic         r_rxd_valid;
   logic         r_rxd_last;

   logic         w_start_edge;
   logic [1:0]   w_area_sel;
   logic [26:0]  w_area_off;
   logic [26:0]  w_base;
   logic [4:0]   w_blen;
   logic         w_busy;
   logic         w_rd_acc;
   logic         w_rd_beat;
   logic         w_wr_beat;
   logic         w_beat;
   logic         w_burst_end;
   logic         w_cmd_end;
   logic         w_tmo_hit;
   logic [3:0]   w_unused_size;

   assign w_start_edge = i_ddr_start & ~r_start_d;
   // Areas above 3 fold onto face 0.
   assign w_area_sel   = (i_ddr_area[3:2] == 2'b00) ? i_ddr_area[1:0] : 2'b00;
   assign w_area_off   = {25'd0, w_area_sel} * P_AREA_WORDS;
   assign w_base       = i_ddr_addr + w_area_off;
   assign w_blen       = (r_rem > {23'd0, c_BURST_MAX}) ? c_BURST_MAX : r_rem[4:0];
   assign w_unused_size = i_ddr_size[3:0];

   assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_rd_acc    = (r_state == S_RD_REQ) & ~i_avm_waitrequest;
   assign w_rd_beat   = (r_state == S_RD_WAIT) & i_avm_readdatavalid;
   assign w_wr_beat   = (r_state == S_WR_BURST) & i_txd_valid & ~i_avm_waitrequest;
   assign w_beat      = w_rd_beat | w_wr_beat;
   assign w_burst_end = w_beat && ((r_beat + 5'd1) == r_blen);
   assign w_cmd_end   = w_burst_end && (r_rem == {23'd0, r_blen});

`ifdef SP_IF_DDR_TMO_EN
   logic [15:0] r_tmo_cnt;
   logic        r_tmo_flag;
   logic        w_progress;

   assign w_progress = w_beat | w_rd_acc;
   assign w_tmo_hit  = w_busy & (r_tmo_cnt == P_TMO_CYC);

   always_ff @(posedge i_clk156m or posedge i_arst) begin
      if (i_arst) begin
         r_tmo_cnt  <= '0;
         r_tmo_flag <= 1'b0;
      end else begin
         if (!w_busy || w_progress) begin
            r_tmo_cnt <= '0;
         end else if (!w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
         end
         if (r_state == S_IDLE) begin
            r_tmo_flag <= 1'b0;
         end else if (w_tmo_hit) begin
            r_tmo_flag <= 1'b1;
         end
      end
   end

   assign o_tmo_err = (r_state == S_DONE) & r_tmo_flag;
`else
   logic [15:0] w_unused_tmo;

   assign w_unused_tmo = P_TMO_CYC;
   assign w_tmo_hit    = 1'b0;
   assign o_tmo_err    = 1'b0;
`endif

   // Every burst returns through LOAD, which sets the fixed endp latency.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_start_edge) w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (r_rem == 28'd0) begin
               w_state_nxt = S_DONE;
            end else if (r_wxr) begin
               w_state_nxt = S_WR_BURST;
            end else begin
               w_state_nxt = S_RD_REQ;
            end
         end
         S_RD_REQ:   if (w_rd_acc) w_state_nxt = S_RD_WAIT;
         S_RD_WAIT:  if (w_burst_end) w_state_nxt = S_LOAD;
         S_WR_BURST: if (w_burst_end) w_state_nxt = S_LOAD;
         S_DONE:     w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
      if (w_tmo_hit) w_state_nxt = S_DONE;
   end

   always_ff @(posedge i_clk156m or posedge i_arst) begin
      if (i_arst) begin
         r_state     <= S_IDLE;
         r_start_d   <= 1'b0;
         r_wxr       <= 1'b0;
         r_addr      <= '0;
         r_rem       <= '0;
         r_blen      <= '0;
         r_beat      <= '0;
         r_rxd_data  <= '0;
         r_rxd_valid <= 1'b0;
         r_rxd_last  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_start_d   <= i_ddr_start;
         r_rxd_valid <= w_rd_beat;
         r_rxd_last  <= w_rd_beat & w_cmd_end;
         if (w_rd_beat) r_rxd_data <= i_avm_readdata;

         if ((r_state == S_IDLE) && w_start_edge) begin
            r_wxr  <= i_ddr_wxr;
            r_addr <= w_base;
            r_rem  <= i_ddr_size[31:4];
         end

         if (r_state == S_LOAD) begin
            r_blen <= w_blen;
            r_beat <= '0;
         end else if (w_beat) begin
            r_beat <= r_beat + 5'd1;
         end

         if (w_burst_end) begin
            r_addr <= r_addr + {22'd0, r_blen};
            r_rem  <= r_rem - {23'd0, r_blen};
         end
      end
   end

   assign o_ddr_endp       = (r_state == S_DONE);
   assign o_busy           = w_busy;
   assign o_avm_address    = r_addr;
   assign o_avm_burstcount = r_blen;
   assign o_avm_read       = (r_state == S_RD_REQ);
   assign o_avm_write      = (r_state == S_WR_BURST) & i_txd_valid;
   assign o_avm_writedata  = (r_state == S_WR_BURST) ? i_txd_data : '0;
   assign o_txd_ready      = (r_state == S_WR_BURST) & ~i_avm_waitrequest;
   assign o_rxd_data       = r_rxd_data;
   assign o_rxd_valid      = r_rxd_valid;
   assign o_rxd_last       = r_rxd_last;

endmodule
`default_nettype wire
